pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the single-cycle core. It is the successor of the fixed 32-bit PC register and adds configurable widths, an asynchronous reset vector, and a hardware return-address stack (RAS) for call/return opcodes. It sits between decode, which supplies `opcode`, `addr`, `jreg` and `condition_bit`, and instruction fetch, which consumes `pc`.

---
 rtl/pc_sequencer.sv | 134 +++++++++++++
 tb/tb_pc_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with a circular return-address stack.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-high reset (pc <= RESET_VECTOR, RAS emptied)
//   halt           freezes pc, RAS, ras_count and ras_err while high
//   opcode         control-flow class from decode
//   condition_bit  branch-taken qualifier for opcodes 110/111
//   addr           immediate target / offset (OFF_WIDTH bits)
//   jreg           register jump target (PC_WIDTH bits)
//   pc             registered program counter
//   ras_count      number of valid RAS entries
//   ras_err        sticky RAS overflow/underflow flag, cleared only by rst
module pc_sequencer #(
    parameter int unsigned           PC_WIDTH     = 32,
    parameter int unsigned           OFF_WIDTH    = 16,
    parameter int unsigned           SHIFT        = 2,
    parameter int unsigned           INC          = 1,
    parameter int unsigned           RAS_DEPTH    = 4,
    parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             halt,
    input  logic [2:0]                       opcode,
    input  logic                             condition_bit,
    input  logic [OFF_WIDTH-1:0]             addr,
    input  logic [PC_WIDTH-1:0]              jreg,
    output logic [PC_WIDTH-1:0]              pc,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
    output logic                             ras_err
);

    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    // Bits of pc replaced by the shifted immediate in an absolute target.
    localparam logic [PC_WIDTH-1:0] LO_MASK = (PC_WIDTH'(1) << (OFF_WIDTH + SHIFT)) - PC_WIDTH'(1);

    typedef enum logic [2:0] {
        OP_SEQ  = 3'b000,
        OP_CALL = 3'b001,
        OP_RET  = 3'b010,
        OP_NOP  = 3'b011,
        OP_JABS = 3'b100,
        OP_JREG = 3'b101,
        OP_BR0  = 3'b110,
        OP_BR1  = 3'b111
    } op_e;

    op_e                  op;
    logic [PC_WIDTH-1:0]  ras [RAS_DEPTH];
    logic [PTR_W-1:0]     top;
    logic [PTR_W-1:0]     top_inc;
    logic [PTR_W-1:0]     top_dec;
    logic [PC_WIDTH-1:0]  seq;
    logic [PC_WIDTH-1:0]  abs_tgt;
    logic [PC_WIDTH-1:0]  rel_tgt;
    logic [PC_WIDTH-1:0]  off_ext;
    logic [PC_WIDTH-1:0]  pc_n;
    logic [PTR_W-1:0]     top_n;
    logic [CNT_W-1:0]     cnt_n;
    logic                 err_n;
    logic                 push;

    assign op = op_e'(opcode);

    always_comb begin
        seq     = pc + PC_WIDTH'(INC);
        off_ext = {{(PC_WIDTH - OFF_WIDTH){addr[OFF_WIDTH-1]}}, addr};
        abs_tgt = (pc & ~LO_MASK) | (PC_WIDTH'(addr) << SHIFT);
        rel_tgt = pc + (off_ext << SHIFT);
        // Pointer arithmetic wraps explicitly so non-power-of-two depths stay circular.
        top_inc = (top == PTR_W'(RAS_DEPTH - 1)) ? '0 : top + PTR_W'(1);
        top_dec = (top == '0) ? PTR_W'(RAS_DEPTH - 1) : top - PTR_W'(1);
    end

    always_comb begin
        pc_n  = seq;
        top_n = top;
        cnt_n = ras_count;
        err_n = ras_err;
        push  = 1'b0;
        case (op)
            OP_SEQ, OP_NOP: pc_n = seq;
            OP_CALL: begin
                pc_n  = abs_tgt;
                push  = 1'b1;
                top_n = top_inc;
                // When full, top+1 is the oldest entry and simply gets overwritten.
                if (ras_count == CNT_W'(RAS_DEPTH)) begin
                    err_n = 1'b1;
                end else begin
                    cnt_n = ras_count + CNT_W'(1);
                end
            end
            OP_RET: begin
                if (ras_count != '0) begin
                    pc_n  = ras[top];
                    top_n = top_dec;
                    cnt_n = ras_count - CNT_W'(1);
                end else begin
                    pc_n  = seq;
                    err_n = 1'b1;
                end
            end
            OP_JABS: pc_n = abs_tgt;
            OP_JREG: pc_n = jreg;
            OP_BR0, OP_BR1: pc_n = condition_bit ? rel_tgt : seq;
            default: pc_n = seq;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_VECTOR;
            top       <= '0;
            ras_count <= '0;
            ras_err   <= 1'b0;
        end else if (!halt) begin
            pc        <= pc_n;
            top       <= top_n;
            ras_count <= cnt_n;
            ras_err   <= err_n;
        end
    end

    // Entry storage needs no reset; validity is tracked by ras_count.
    always_ff @(posedge clk) begin
        if (!rst && !halt && push) begin
            ras[top_inc] <= seq;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer
// (RESET_VECTOR = 0x100, default widths, RAS_DEPTH = 4).
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        halt = 1'b0;
    logic [2:0]  opcode = 3'b000;
    logic        condition_bit = 1'b0;
    logic [15:0] addr = '0;
    logic [31:0] jreg = '0;
    logic [31:0] pc;
    logic [2:0]  ras_count;
    logic        ras_err;

    int unsigned passed = 0;
    int unsigned total  = 0;

    pc_sequencer #(
        .PC_WIDTH    (32),
        .OFF_WIDTH   (16),
        .SHIFT       (2),
        .INC         (1),
        .RAS_DEPTH   (4),
        .RESET_VECTOR(32'h0000_0100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .halt         (halt),
        .opcode       (opcode),
        .condition_bit(condition_bit),
        .addr         (addr),
        .jreg         (jreg),
        .pc           (pc),
        .ras_count    (ras_count),
        .ras_err      (ras_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Drive one instruction, let one edge pass, sample 1 time unit later.
    task automatic step(input logic [2:0] op, input logic [15:0] a, input logic [31:0] j, input logic c);
        opcode        = op;
        addr          = a;
        jreg          = j;
        condition_bit = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Asynchronous reset between clock edges
        #3 rst = 1'b1;
        #1;
        check("rst_pc_async", pc, 32'h100);
        check("rst_count", {29'b0, ras_count}, 32'd0);
        check("rst_err", {31'b0, ras_err}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Sequential
        step(3'b000, 16'h0, 32'h0, 1'b0); check("seq1", pc, 32'h101);
        step(3'b000, 16'h0, 32'h0, 1'b0); check("seq2", pc, 32'h102);
        step(3'b000, 16'h0, 32'h0, 1'b0); check("seq3", pc, 32'h103);
        step(3'b011, 16'h0, 32'h0, 1'b0); check("op011", pc, 32'h104);

        // Relative branches
        step(3'b101, 16'h0, 32'h40, 1'b0);
        step(3'b110, 16'hFFFF, 32'h0, 1'b1); check("br_taken", pc, 32'h3C);
        step(3'b101, 16'h0, 32'h40, 1'b0);
        step(3'b110, 16'hFFFF, 32'h0, 1'b0); check("br_not_taken", pc, 32'h41);
        step(3'b111, 16'h0003, 32'h0, 1'b1); check("br111_fwd", pc, 32'h4D);

        // Absolute and register jumps
        step(3'b101, 16'h0, 32'hABC00010, 1'b0);
        step(3'b100, 16'h1234, 32'h0, 1'b0); check("jabs", pc, 32'hABC048D0);
        step(3'b101, 16'h0, 32'hDEADBEEF, 1'b0); check("jreg", pc, 32'hDEADBEEF);

        // Nested call / return
        step(3'b101, 16'h0, 32'h10, 1'b0);
        step(3'b001, 16'h0020, 32'h0, 1'b0); check("call1_pc", pc, 32'h80);
        check("call1_cnt", {29'b0, ras_count}, 32'd1);
        step(3'b001, 16'h0040, 32'h0, 1'b0); check("call2_pc", pc, 32'h100);
        check("call2_cnt", {29'b0, ras_count}, 32'd2);
        step(3'b010, 16'h0, 32'h0, 1'b0); check("ret1_pc", pc, 32'h81);
        step(3'b010, 16'h0, 32'h0, 1'b0); check("ret2_pc", pc, 32'h11);
        check("ret2_cnt", {29'b0, ras_count}, 32'd0);
        check("ret2_err", {31'b0, ras_err}, 32'd0);

        // Back-to-back call then return
        step(3'b001, 16'h0020, 32'h0, 1'b0); check("b2b_call", pc, 32'h80);
        step(3'b010, 16'h0, 32'h0, 1'b0); check("b2b_ret", pc, 32'h12);

        // Overflow: 5 calls into a 4-deep RAS
        step(3'b101, 16'h0, 32'h200, 1'b0);
        step(3'b001, 16'h0100, 32'h0, 1'b0);  // push 0x201
        step(3'b001, 16'h0200, 32'h0, 1'b0);  // push 0x401
        step(3'b001, 16'h0300, 32'h0, 1'b0);  // push 0x801
        step(3'b001, 16'h0400, 32'h0, 1'b0);  // push 0xC01
        check("full_cnt", {29'b0, ras_count}, 32'd4);
        check("full_err", {31'b0, ras_err}, 32'd0);
        step(3'b001, 16'h0500, 32'h0, 1'b0);  // push 0x1001, overwrites 0x201
        check("ovf_pc", pc, 32'h1400);
        check("ovf_cnt", {29'b0, ras_count}, 32'd4);
        check("ovf_err", {31'b0, ras_err}, 32'd1);
        step(3'b010, 16'h0, 32'h0, 1'b0); check("ovf_ret5", pc, 32'h1001);
        step(3'b010, 16'h0, 32'h0, 1'b0); check("ovf_ret4", pc, 32'hC01);
        step(3'b010, 16'h0, 32'h0, 1'b0); check("ovf_ret3", pc, 32'h801);
        step(3'b010, 16'h0, 32'h0, 1'b0); check("ovf_ret2", pc, 32'h401);
        check("drain_cnt", {29'b0, ras_count}, 32'd0);
        // Underflow
        step(3'b010, 16'h0, 32'h0, 1'b0); check("unf_pc", pc, 32'h402);
        check("unf_err", {31'b0, ras_err}, 32'd1);
        check("unf_cnt", {29'b0, ras_count}, 32'd0);

        // Reset mid-sequence discards call context and clears ras_err
        step(3'b001, 16'h0020, 32'h0, 1'b0); check("pre_rst_cnt", {29'b0, ras_count}, 32'd1);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_pc", pc, 32'h100);
        check("mid_rst_cnt", {29'b0, ras_count}, 32'd0);
        check("mid_rst_err", {31'b0, ras_err}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(3'b010, 16'h0, 32'h0, 1'b0); check("post_rst_ret_pc", pc, 32'h101);
        check("post_rst_ret_err", {31'b0, ras_err}, 32'd1);

        // Halt freezes state; held opcode is not replayed
        step(3'b101, 16'h0, 32'h300, 1'b0);
        halt = 1'b1;
        step(3'b001, 16'h0020, 32'h0, 1'b0);
        step(3'b001, 16'h0020, 32'h0, 1'b0);
        check("halt_pc", pc, 32'h300);
        check("halt_cnt", {29'b0, ras_count}, 32'd0);
        halt = 1'b0;
        step(3'b000, 16'h0, 32'h0, 1'b0); check("unhalt_pc", pc, 32'h301);
        check("unhalt_cnt", {29'b0, ras_count}, 32'd0);

        // Wrap-around
        step(3'b101, 16'h0, 32'hFFFFFFFF, 1'b0);
        step(3'b000, 16'h0, 32'h0, 1'b0); check("wrap", pc, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
